// File: rtl/rx_frame_checker_if.sv
// rx_frame_checker_if
// Groups the frame-input and held-frame-output handshake of rx_frame_checker.
//   frame_valid/raw_data/start_bit/parity_bit/stop_bits/parity_mode : sampled frame fields
//   out_ready                                                        : consumer accepts held frame
//   out_valid/out_data/out_error                                     : held frame and its errors
// The master modport is the frame producer + consumer side; the slave modport is the checker.
interface rx_frame_checker_if #(
   parameter int DATA_WIDTH = 8,
   parameter int STOP_BITS  = 1
);
   logic                  frame_valid;
   logic [DATA_WIDTH-1:0] raw_data;
   logic                  start_bit;
   logic                  parity_bit;
   logic [STOP_BITS-1:0]  stop_bits;
   logic [2:0]            parity_mode;
   logic                  out_ready;
   logic                  out_valid;
   logic [DATA_WIDTH-1:0] out_data;
   logic [3:0]            out_error;

   modport master (
      output frame_valid, raw_data, start_bit, parity_bit, stop_bits, parity_mode, out_ready,
      input  out_valid, out_data, out_error
   );

   modport slave (
      input  frame_valid, raw_data, start_bit, parity_bit, stop_bits, parity_mode, out_ready,
      output out_valid, out_data, out_error
   );
endinterface

// File: rtl/rx_frame_checker.sv
// rx_frame_checker
// Checks parity/start/stop/break on each received UART-style frame, holds the
// frame for a ready/valid consumer, and keeps sticky status plus saturating
// error counters.
// Ports:
//   clock, reset        : rising-edge clock, synchronous active-high reset
//   bus (slave)         : frame input fields and held-frame output handshake
//   clear_stats         : one-cycle pulse clearing sticky_status and counters
//   sticky_status       : {overrun, break, stop, start, parity}, OR-accumulated
//   parity_err_cnt      : accepted frames with a parity error
//   framing_err_cnt     : accepted frames with a start, stop or break error
//   overrun_cnt         : frames dropped because the held frame was not taken
module rx_frame_checker #(
   parameter int DATA_WIDTH = 8,
   parameter int STOP_BITS  = 1,
   parameter int CNT_WIDTH  = 8
) (
   input  logic                 clock,
   input  logic                 reset,
   rx_frame_checker_if.slave    bus,
   input  logic                 clear_stats,
   output logic [4:0]           sticky_status,
   output logic [CNT_WIDTH-1:0] parity_err_cnt,
   output logic [CNT_WIDTH-1:0] framing_err_cnt,
   output logic [CNT_WIDTH-1:0] overrun_cnt
);

   localparam logic [0:0] EMPTY = 1'b0;
   localparam logic [0:0] HOLD  = 1'b1;

   localparam logic [2:0] PAR_ODD   = 3'b001;
   localparam logic [2:0] PAR_EVEN  = 3'b010;
   localparam logic [2:0] PAR_MARK  = 3'b011;
   localparam logic [2:0] PAR_SPACE = 3'b100;

   // Parity check for the selected mode; undefined codes behave as "none".
   function automatic logic parity_error(input logic [DATA_WIDTH-1:0] data,
                                         input logic pbit, input logic [2:0] mode);
      logic err;
      err = 1'b0;
      case (mode)
         PAR_ODD:   err = ~(^data ^ pbit);
         PAR_EVEN:  err = ^data ^ pbit;
         PAR_MARK:  err = ~pbit;
         PAR_SPACE: err = pbit;
         default:   err = 1'b0;
      endcase
      return err;
   endfunction

   // True when the parity bit is meaningful for this mode.
   function automatic logic parity_enabled(input logic [2:0] mode);
      logic en;
      en = 1'b0;
      case (mode)
         PAR_ODD, PAR_EVEN, PAR_MARK, PAR_SPACE: en = 1'b1;
         default:                                en = 1'b0;
      endcase
      return en;
   endfunction

   // Saturating increment: holds at all-ones instead of wrapping.
   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] value,
                                                    input logic inc);
      logic [CNT_WIDTH-1:0] res;
      if (inc && (value != {CNT_WIDTH{1'b1}})) begin
         res = value + CNT_WIDTH'(1'b1);
      end else begin
         res = value;
      end
      return res;
   endfunction

   logic [0:0]            state_r;
   logic [0:0]            state_nx_s;
   logic [DATA_WIDTH-1:0] data_r;
   logic [3:0]            err_r;
   logic [4:0]            sticky_r;
   logic [CNT_WIDTH-1:0]  par_cnt_r;
   logic [CNT_WIDTH-1:0]  frm_cnt_r;
   logic [CNT_WIDTH-1:0]  ovr_cnt_r;

   logic       brk_s;
   logic [3:0] frame_err_s;
   logic       accept_s;
   logic       overrun_s;
   logic [4:0] event_s;
   logic       par_inc_s;
   logic       frm_inc_s;

   // Frame error classification, accept/overrun decision and next state.
   always_comb begin
      brk_s = (bus.raw_data == {DATA_WIDTH{1'b0}}) && !bus.start_bit &&
              (bus.stop_bits == {STOP_BITS{1'b0}}) &&
              (!parity_enabled(bus.parity_mode) || !bus.parity_bit);
      // A break looks like a stop/parity failure; report it only as a break.
      frame_err_s = {brk_s,
                     ~(&bus.stop_bits) & ~brk_s,
                     bus.start_bit,
                     parity_error(bus.raw_data, bus.parity_bit, bus.parity_mode) & ~brk_s};
      accept_s  = bus.frame_valid && ((state_r == EMPTY) || bus.out_ready);
      overrun_s = bus.frame_valid && (state_r == HOLD) && !bus.out_ready;
      // Dropped frames contribute only the overrun bit, never their own errors.
      event_s   = {overrun_s, accept_s ? frame_err_s : 4'b0000};
      par_inc_s = event_s[0];
      frm_inc_s = |event_s[3:1];

      state_nx_s = state_r;
      case (state_r)
         EMPTY: begin
            if (bus.frame_valid) begin
               state_nx_s = HOLD;
            end else begin
               state_nx_s = EMPTY;
            end
         end
         HOLD: begin
            if (bus.out_ready && !bus.frame_valid) begin
               state_nx_s = EMPTY;
            end else begin
               state_nx_s = HOLD;
            end
         end
         default: state_nx_s = EMPTY;
      endcase
   end

   // FSM and held frame registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r <= EMPTY;
         data_r  <= {DATA_WIDTH{1'b0}};
         err_r   <= 4'b0000;
      end else begin
         state_r <= state_nx_s;
         if (accept_s) begin
            data_r <= bus.raw_data;
            err_r  <= frame_err_s;
         end
      end
   end

   // Sticky status and counters; a clear coincident with an event keeps just that event.
   always_ff @(posedge clock) begin
      if (reset) begin
         sticky_r  <= 5'b00000;
         par_cnt_r <= {CNT_WIDTH{1'b0}};
         frm_cnt_r <= {CNT_WIDTH{1'b0}};
         ovr_cnt_r <= {CNT_WIDTH{1'b0}};
      end else begin
         sticky_r  <= (clear_stats ? 5'b00000 : sticky_r) | event_s;
         par_cnt_r <= sat_inc(clear_stats ? {CNT_WIDTH{1'b0}} : par_cnt_r, par_inc_s);
         frm_cnt_r <= sat_inc(clear_stats ? {CNT_WIDTH{1'b0}} : frm_cnt_r, frm_inc_s);
         ovr_cnt_r <= sat_inc(clear_stats ? {CNT_WIDTH{1'b0}} : ovr_cnt_r, overrun_s);
      end
   end

   assign bus.out_valid    = (state_r == HOLD);
   assign bus.out_data     = data_r;
   assign bus.out_error    = err_r;
   assign sticky_status    = sticky_r;
   assign parity_err_cnt   = par_cnt_r;
   assign framing_err_cnt  = frm_cnt_r;
   assign overrun_cnt      = ovr_cnt_r;

endmodule

// File: tb/tb_rx_frame_checker.sv
// tb_rx_frame_checker
// Directed, table-driven bench for rx_frame_checker. dut_a uses default
// parameters; dut_b uses CNT_WIDTH=2, STOP_BITS=2 for saturation and
// two-stop-bit cases.
module tb_rx_frame_checker;

   logic clk;
   logic rst_a;
   logic rst_b;
   logic clr_a;
   logic clr_b;
   logic [4:0] sticky_a;
   logic [4:0] sticky_b;
   logic [7:0] pcnt_a, fcnt_a, ocnt_a;
   logic [1:0] pcnt_b, fcnt_b, ocnt_b;

   int n_cmp = 0;
   int n_err = 0;

   rx_frame_checker_if #(.DATA_WIDTH(8), .STOP_BITS(1)) bus_a ();
   rx_frame_checker_if #(.DATA_WIDTH(8), .STOP_BITS(2)) bus_b ();

   rx_frame_checker #(.DATA_WIDTH(8), .STOP_BITS(1), .CNT_WIDTH(8)) dut_a (
      .clock(clk), .reset(rst_a), .bus(bus_a.slave), .clear_stats(clr_a),
      .sticky_status(sticky_a), .parity_err_cnt(pcnt_a),
      .framing_err_cnt(fcnt_a), .overrun_cnt(ocnt_a)
   );

   rx_frame_checker #(.DATA_WIDTH(8), .STOP_BITS(2), .CNT_WIDTH(2)) dut_b (
      .clock(clk), .reset(rst_b), .bus(bus_b.slave), .clear_stats(clr_b),
      .sticky_status(sticky_b), .parity_err_cnt(pcnt_b),
      .framing_err_cnt(fcnt_b), .overrun_cnt(ocnt_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       fv;
      logic [7:0] raw;
      logic       st;
      logic       pb;
      logic       sp;
      logic [2:0] mode;
      logic       rdy;
      logic       clr;
      logic       e_ov;
      logic [7:0] e_data;
      logic [3:0] e_err;
      logic [4:0] e_sticky;
      logic [7:0] e_p;
      logic [7:0] e_f;
      logic [7:0] e_o;
   } vec_t;

   vec_t vecs[17];

   function automatic vec_t mk(logic fv, logic [7:0] raw, logic st, logic pb, logic sp,
                               logic [2:0] mode, logic rdy, logic clr, logic e_ov,
                               logic [7:0] e_data, logic [3:0] e_err, logic [4:0] e_sticky,
                               logic [7:0] e_p, logic [7:0] e_f, logic [7:0] e_o);
      vec_t v;
      v.fv = fv; v.raw = raw; v.st = st; v.pb = pb; v.sp = sp; v.mode = mode;
      v.rdy = rdy; v.clr = clr; v.e_ov = e_ov; v.e_data = e_data; v.e_err = e_err;
      v.e_sticky = e_sticky; v.e_p = e_p; v.e_f = e_f; v.e_o = e_o;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_a(input logic fv, input logic [7:0] raw, input logic st, input logic pb,
                          input logic sp, input logic [2:0] mode, input logic rdy);
      bus_a.frame_valid = fv;
      bus_a.raw_data    = raw;
      bus_a.start_bit   = st;
      bus_a.parity_bit  = pb;
      bus_a.stop_bits   = sp;
      bus_a.parity_mode = mode;
      bus_a.out_ready   = rdy;
   endtask

   initial begin
      // fv  raw    st    pb    sp    mode    rdy   clr   ov    data   err      sticky     p  f  o
      vecs[0]  = mk(1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 3'b010, 1'b1, 1'b0, 1'b1, 8'hA5, 4'b0000, 5'b00000, 8'd0, 8'd0, 8'd0);
      vecs[1]  = mk(1'b1, 8'h01, 1'b0, 1'b1, 1'b1, 3'b001, 1'b1, 1'b0, 1'b1, 8'h01, 4'b0001, 5'b00001, 8'd1, 8'd0, 8'd0);
      vecs[2]  = mk(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 3'b010, 1'b1, 1'b0, 1'b1, 8'h00, 4'b1000, 5'b01001, 8'd1, 8'd1, 8'd0);
      vecs[3]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 8'h00, 4'b0000, 5'b01001, 8'd1, 8'd1, 8'd0);
      vecs[4]  = mk(1'b1, 8'h3C, 1'b0, 1'b1, 1'b1, 3'b000, 1'b0, 1'b0, 1'b1, 8'h3C, 4'b0000, 5'b01001, 8'd1, 8'd1, 8'd0);
      vecs[5]  = mk(1'b1, 8'hFF, 1'b1, 1'b0, 1'b1, 3'b011, 1'b0, 1'b0, 1'b1, 8'h3C, 4'b0000, 5'b11001, 8'd1, 8'd1, 8'd1);
      vecs[6]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b1, 8'h3C, 4'b0000, 5'b11001, 8'd1, 8'd1, 8'd1);
      vecs[7]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 8'h00, 4'b0000, 5'b11001, 8'd1, 8'd1, 8'd1);
      vecs[8]  = mk(1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 3'b011, 1'b0, 1'b0, 1'b1, 8'h55, 4'b0001, 5'b11001, 8'd2, 8'd1, 8'd1);
      vecs[9]  = mk(1'b1, 8'h55, 1'b1, 1'b1, 1'b1, 3'b100, 1'b1, 1'b0, 1'b1, 8'h55, 4'b0011, 5'b11011, 8'd3, 8'd2, 8'd1);
      vecs[10] = mk(1'b1, 8'h81, 1'b0, 1'b1, 1'b0, 3'b101, 1'b1, 1'b1, 1'b1, 8'h81, 4'b0100, 5'b00100, 8'd0, 8'd1, 8'd0);
      vecs[11] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 1'b1, 1'b1, 8'h81, 4'b0100, 5'b00000, 8'd0, 8'd0, 8'd0);
      vecs[12] = mk(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 3'b010, 1'b0, 1'b1, 1'b1, 8'h81, 4'b0100, 5'b10000, 8'd0, 8'd0, 8'd1);
      vecs[13] = mk(1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 3'b001, 1'b1, 1'b0, 1'b1, 8'h00, 4'b0100, 5'b10100, 8'd0, 8'd1, 8'd1);
      vecs[14] = mk(1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 3'b000, 1'b1, 1'b0, 1'b1, 8'h00, 4'b1000, 5'b11100, 8'd0, 8'd2, 8'd1);
      vecs[15] = mk(1'b1, 8'hA5, 1'b0, 1'b1, 1'b1, 3'b010, 1'b1, 1'b0, 1'b1, 8'hA5, 4'b0001, 5'b11101, 8'd1, 8'd2, 8'd1);
      vecs[16] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 8'h00, 4'b0000, 5'b11101, 8'd1, 8'd2, 8'd1);

      // Reset with a coincident frame on both instances.
      rst_a = 1'b1; rst_b = 1'b1; clr_a = 1'b0; clr_b = 1'b0;
      drive_a(1'b1, 8'h5A, 1'b0, 1'b0, 1'b1, 3'b010, 1'b0);
      bus_b.frame_valid = 1'b1; bus_b.raw_data = 8'h5A; bus_b.start_bit = 1'b0;
      bus_b.parity_bit = 1'b0; bus_b.stop_bits = 2'b11; bus_b.parity_mode = 3'b010;
      bus_b.out_ready = 1'b0;
      step();
      step();
      chk("rst_a_valid", {31'd0, bus_a.out_valid}, 32'd0);
      chk("rst_a_data", {24'd0, bus_a.out_data}, 32'd0);
      chk("rst_a_err", {28'd0, bus_a.out_error}, 32'd0);
      chk("rst_a_sticky", {27'd0, sticky_a}, 32'd0);
      chk("rst_a_cnts", {8'd0, pcnt_a, fcnt_a, ocnt_a}, 32'd0);
      chk("rst_b_valid", {31'd0, bus_b.out_valid}, 32'd0);
      rst_a = 1'b0; rst_b = 1'b0;
      drive_a(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0);
      bus_b.frame_valid = 1'b0;

      // Table-driven sweep on dut_a.
      for (int i = 0; i < 17; i++) begin
         drive_a(vecs[i].fv, vecs[i].raw, vecs[i].st, vecs[i].pb, vecs[i].sp,
                 vecs[i].mode, vecs[i].rdy);
         clr_a = vecs[i].clr;
         step();
         chk($sformatf("v%0d_valid", i), {31'd0, bus_a.out_valid}, {31'd0, vecs[i].e_ov});
         if (vecs[i].e_ov) begin
            chk($sformatf("v%0d_data", i), {24'd0, bus_a.out_data}, {24'd0, vecs[i].e_data});
            chk($sformatf("v%0d_err", i), {28'd0, bus_a.out_error}, {28'd0, vecs[i].e_err});
         end
         chk($sformatf("v%0d_sticky", i), {27'd0, sticky_a}, {27'd0, vecs[i].e_sticky});
         chk($sformatf("v%0d_pcnt", i), {24'd0, pcnt_a}, {24'd0, vecs[i].e_p});
         chk($sformatf("v%0d_fcnt", i), {24'd0, fcnt_a}, {24'd0, vecs[i].e_f});
         chk($sformatf("v%0d_ocnt", i), {24'd0, ocnt_a}, {24'd0, vecs[i].e_o});
      end
      clr_a = 1'b0;

      // dut_a: reset while holding a frame, with a coincident new frame.
      drive_a(1'b1, 8'hC3, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0);
      step();
      chk("hold_a_valid", {31'd0, bus_a.out_valid}, 32'd1);
      chk("hold_a_data", {24'd0, bus_a.out_data}, 32'hC3);
      drive_a(1'b1, 8'h77, 1'b0, 1'b0, 1'b1, 3'b000, 1'b1);
      rst_a = 1'b1;
      step();
      chk("midrst_a_valid", {31'd0, bus_a.out_valid}, 32'd0);
      chk("midrst_a_data", {24'd0, bus_a.out_data}, 32'd0);
      chk("midrst_a_err", {28'd0, bus_a.out_error}, 32'd0);
      chk("midrst_a_stats", {3'd0, sticky_a, pcnt_a, fcnt_a, ocnt_a}, 32'd0);
      rst_a = 1'b0;
      drive_a(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3'b000, 1'b1);
      step();
      chk("post_rst_a_valid", {31'd0, bus_a.out_valid}, 32'd0);

      // dut_b: five back-to-back odd-parity errors, frame_valid held high.
      bus_b.frame_valid = 1'b1; bus_b.raw_data = 8'h01; bus_b.start_bit = 1'b0;
      bus_b.parity_bit = 1'b1; bus_b.stop_bits = 2'b11; bus_b.parity_mode = 3'b001;
      bus_b.out_ready = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         step();
         chk($sformatf("sat_b%0d_pcnt", k), {30'd0, pcnt_b}, (k < 3) ? k : 32'd3);
         chk($sformatf("sat_b%0d_err", k), {28'd0, bus_b.out_error}, 32'h1);
      end
      chk("sat_b_valid", {31'd0, bus_b.out_valid}, 32'd1);
      clr_b = 1'b1;
      step();
      chk("clr_b_pcnt", {30'd0, pcnt_b}, 32'd1);
      chk("clr_b_fcnt", {30'd0, fcnt_b}, 32'd0);
      chk("clr_b_sticky", {27'd0, sticky_b}, 32'h01);
      clr_b = 1'b0;

      // dut_b: second stop bit low -> stop error.
      bus_b.raw_data = 8'h5A; bus_b.parity_bit = 1'b0; bus_b.stop_bits = 2'b10;
      bus_b.parity_mode = 3'b000;
      step();
      chk("stop2_b_err", {28'd0, bus_b.out_error}, 32'h4);
      chk("stop2_b_data", {24'd0, bus_b.out_data}, 32'h5A);
      chk("stop2_b_fcnt", {30'd0, fcnt_b}, 32'd1);
      chk("stop2_b_sticky", {27'd0, sticky_b}, 32'h05);
      bus_b.frame_valid = 1'b0; bus_b.out_ready = 1'b0;
      step();
      chk("hold_b_valid", {31'd0, bus_b.out_valid}, 32'd1);
      chk("hold_b_err", {28'd0, bus_b.out_error}, 32'h4);
      rst_b = 1'b1;
      step();
      chk("midrst_b_valid", {31'd0, bus_b.out_valid}, 32'd0);
      chk("midrst_b_data", {24'd0, bus_b.out_data}, 32'd0);
      chk("midrst_b_err", {28'd0, bus_b.out_error}, 32'd0);
      chk("midrst_b_stats", {21'd0, sticky_b, pcnt_b, fcnt_b, ocnt_b}, 32'd0);
      rst_b = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
